// File: rtl/sr_pkg.sv
// Shared types and helpers for the S/R flop command stage.
// State encoding, command constants and timer sizing.
package sr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE_S = 2'd1,
        ST_DRIVE_R = 2'd2,
        ST_GAP     = 2'd3
    } sr_state_e;

    localparam logic CMD_SET = 1'b1;
    localparam logic CMD_CLR = 1'b0;

    // Width needed to hold max(pulse, gap); never below 1 bit.
    function automatic int tmr_width(
        input int pulse,
        input int gap
    );
        int m;
        int w;
        m = (pulse > gap) ? pulse : gap;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sr_dwell_timer.sv
// Loadable down-counter shared by DRIVE and GAP dwell.
// Stops at zero; o_zero flags the final cycle of a dwell.
module sr_dwell_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_val  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sr_drive_ctrl.sv
// Command stage for sr_flipflop: timed, exclusive S/R pulses.
// Optional readback check enabled by SR_READBACK_CHECK_EN.
module sr_drive_ctrl
    import sr_pkg::*;
#(
    parameter int PULSE_CYC      = 4,
    parameter int GAP_CYC        = 2,
    parameter int SET_PRIORITY   = 0,
    parameter int SKIP_REDUNDANT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    output logic cmd_ready,
    output logic s_out,
    output logic r_out,
    output logic done,
    output logic shadow_q,
    output logic shadow_vld,
    input  logic q_fb,
    input  logic err_clr,
    output logic err
);

    localparam int TW = tmr_width(PULSE_CYC, GAP_CYC);
    localparam int GAP_M1 = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'(GAP_M1);

    sr_state_e r_state;
    sr_state_e w_state_nxt;

    logic          r_s_out;
    logic          r_r_out;
    logic          r_done;
    logic          r_shadow_q;
    logic          r_shadow_vld;
    logic          r_chk;

    logic          w_req;
    logic          w_cmd;
    logic          w_redund;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic [TW-1:0] w_tmr_val;
    logic          w_zero;
    logic          w_done_nxt;
    logic          w_sq_nxt;
    logic          w_sv_nxt;
    logic          w_pulse_end;

    sr_dwell_timer #(
        .W (TW)
    ) u_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_val  (w_load_val),
        .o_val  (w_tmr_val),
        .o_zero (w_zero)
    );

    assign w_req = set_req | clr_req;
    assign w_cmd = (set_req & clr_req) ?
                   ((SET_PRIORITY != 0) ? CMD_SET : CMD_CLR) :
                   (set_req ? CMD_SET : CMD_CLR);
    assign w_redund = (SKIP_REDUNDANT != 0) & r_shadow_vld &
                      (w_cmd == r_shadow_q);

    // Next-state, timer load and completion bookkeeping.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = PULSE_LD;
        w_done_nxt  = 1'b0;
        w_sq_nxt    = r_shadow_q;
        w_sv_nxt    = r_shadow_vld;
        w_pulse_end = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_redund) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = (w_cmd == CMD_SET) ?
                                      ST_DRIVE_S : ST_DRIVE_R;
                        w_load = 1'b1;
                    end
                end
            end
            ST_DRIVE_S, ST_DRIVE_R: begin
                if (w_zero) begin
                    w_done_nxt  = 1'b1;
                    w_pulse_end = 1'b1;
                    w_sq_nxt    = (r_state == ST_DRIVE_S);
                    w_sv_nxt    = 1'b1;
                    if (GAP_CYC > 0) begin
                        w_state_nxt = ST_GAP;
                        w_load      = 1'b1;
                        w_load_val  = GAP_LD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (w_zero) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and registered drive/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_s_out      <= 1'b0;
            r_r_out      <= 1'b0;
            r_done       <= 1'b0;
            r_shadow_q   <= 1'b0;
            r_shadow_vld <= 1'b0;
            r_chk        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_s_out      <= (w_state_nxt == ST_DRIVE_S);
            r_r_out      <= (w_state_nxt == ST_DRIVE_R);
            r_done       <= w_done_nxt;
            r_shadow_q   <= w_sq_nxt;
            r_shadow_vld <= w_sv_nxt;
            r_chk        <= w_pulse_end;
        end
    end

`ifdef SR_READBACK_CHECK_EN
    logic r_err;

    // Sticky mismatch flag; a new mismatch beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_chk && (q_fb != r_shadow_q)) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
    logic w_unused_tmr;
    assign w_unused_tmr = ^w_tmr_val;
`else
    logic w_unused_rb;
    assign w_unused_rb = ^{q_fb, err_clr, r_chk, w_tmr_val};
    assign err = 1'b0;
`endif

    assign cmd_ready  = (r_state == ST_IDLE);
    assign s_out      = r_s_out;
    assign r_out      = r_r_out;
    assign done       = r_done;
    assign shadow_q   = r_shadow_q;
    assign shadow_vld = r_shadow_vld;

endmodule
